// File: rtl/pwm_multichannel.sv
// N-channel PWM generator with prescaler, programmable period and per-channel polarity.
// TOP and DUTY are double-buffered and only take effect when the period counter wraps.
module pwm_multichannel #(
    parameter int unsigned NUM_CH  = 16,
    parameter int unsigned PRESC_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [6:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [6:0]        rd_addr,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    localparam int unsigned NB = (NUM_CH + 7) / 8;

    logic [NUM_CH-1:0]  oen_q, oen_d, pen_q, pen_d, pol_q, pol_d;
    logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
    logic [7:0]         top_s_q, top_s_d, top_a_q, top_a_d, cnt_q, cnt_d;
    logic [7:0]         duty_s_q [NUM_CH];
    logic [7:0]         duty_s_d [NUM_CH];
    logic [7:0]         duty_a_q [NUM_CH];
    logic [7:0]         duty_a_d [NUM_CH];
    logic [NUM_CH-1:0]  raw, out_d;
    logic [7:0]         rd_d;
    logic               tick, wrap, presc_wr;

    // Register writes; bit-per-channel bytes only store bits of existing channels.
    always_comb begin
        oen_d    = oen_q;
        pen_d    = pen_q;
        pol_d    = pol_q;
        presc_d  = presc_q;
        top_s_d  = top_s_q;
        duty_s_d = duty_s_q;
        if (wr_valid) begin
            for (int unsigned k = 0; k < NB; k++) begin
                for (int unsigned j = 0; j < 8; j++) begin
                    if (k * 8 + j < NUM_CH) begin
                        if (wr_addr == 7'(k))      oen_d[k*8+j] = wr_data[j[2:0]];
                        if (wr_addr == 7'(16 + k)) pen_d[k*8+j] = wr_data[j[2:0]];
                        if (wr_addr == 7'(32 + k)) pol_d[k*8+j] = wr_data[j[2:0]];
                    end
                end
            end
            for (int unsigned b = 0; b < PRESC_W; b++) begin
                if (wr_addr == ((b < 8) ? 7'h30 : 7'h31)) presc_d[b] = wr_data[b[2:0]];
            end
            if (wr_addr == 7'h32) top_s_d = wr_data;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (wr_addr == 7'(64 + c)) duty_s_d[c] = wr_data;
            end
        end
    end

    // Prescaler and period counter; staging registers move to active on wrap.
    always_comb begin
        tick     = (pcnt_q == presc_q);
        wrap     = tick && (cnt_q == top_a_q);
        presc_wr = wr_valid && ((wr_addr == 7'h30) || (wr_addr == 7'h31));
        pcnt_d   = (presc_wr || tick) ? '0 : pcnt_q + PRESC_W'(1);
        cnt_d    = cnt_q;
        top_a_d  = top_a_q;
        duty_a_d = duty_a_q;
        if (wrap) begin
            cnt_d    = '0;
            top_a_d  = top_s_q;
            duty_a_d = duty_s_q;
        end else if (tick) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            raw[c]   = ((duty_a_q[c] == 8'hFF) || (duty_a_q[c] > top_a_q)) ? 1'b1
                                                                           : (cnt_q < duty_a_q[c]);
            out_d[c] = oen_q[c] & (pen_q[c] ? (raw[c] ^ pol_q[c]) : ~pol_q[c]);
        end
    end

    // Read mux sees pre-write values, so a same-cycle write is not forwarded.
    always_comb begin
        rd_d = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            for (int unsigned j = 0; j < 8; j++) begin
                if (k * 8 + j < NUM_CH) begin
                    if (rd_addr == 7'(k))      rd_d[j[2:0]] = oen_q[k*8+j];
                    if (rd_addr == 7'(16 + k)) rd_d[j[2:0]] = pen_q[k*8+j];
                    if (rd_addr == 7'(32 + k)) rd_d[j[2:0]] = pol_q[k*8+j];
                end
            end
        end
        for (int unsigned b = 0; b < PRESC_W; b++) begin
            if (rd_addr == ((b < 8) ? 7'h30 : 7'h31)) rd_d[b[2:0]] = presc_q[b];
        end
        if (rd_addr == 7'h32) rd_d = top_s_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (rd_addr == 7'(64 + c)) rd_d = duty_s_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oen_q        <= '0;
            pen_q        <= '0;
            pol_q        <= '0;
            presc_q      <= '0;
            pcnt_q       <= '0;
            top_s_q      <= '0;
            top_a_q      <= '0;
            cnt_q        <= '0;
            rd_data      <= '0;
            out          <= '0;
            period_start <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                duty_s_q[c] <= '0;
                duty_a_q[c] <= '0;
            end
        end else begin
            oen_q        <= oen_d;
            pen_q        <= pen_d;
            pol_q        <= pol_d;
            presc_q      <= presc_d;
            pcnt_q       <= pcnt_d;
            top_s_q      <= top_s_d;
            top_a_q      <= top_a_d;
            cnt_q        <= cnt_d;
            rd_data      <= rd_d;
            out          <= out_d;
            period_start <= wrap;
            duty_s_q     <= duty_s_d;
            duty_a_q     <= duty_a_d;
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Randomised bench for pwm_multichannel against a flat register-image reference model,
// plus directed checks of duty counts, double buffering, modes, prescaler and address limits.
module tb_pwm_multichannel;

    localparam int NUM_CH  = 10;
    localparam int PRESC_W = 12;
    localparam int NB      = (NUM_CH + 7) / 8;

    logic              clk = 1'b0;
    logic              rst, wr_valid;
    logic [6:0]        wr_addr, rd_addr;
    logic [7:0]        wr_data, rd_data;
    logic [NUM_CH-1:0] dut_out;
    logic              period_start;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    pwm_multichannel #(
        .NUM_CH (NUM_CH),
        .PRESC_W(PRESC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .out         (dut_out),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    // Reference model: a 128-byte register image plus the period position.
    logic [7:0]        m_mem [128];
    int                m_duty_a [NUM_CH];
    int                m_pcnt, m_cnt, m_top_a;
    logic [NUM_CH-1:0] m_out;
    logic              m_ps;
    logic [7:0]        m_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [7:0] store_mask(input int a);
        logic [7:0] m = '0;
        if (a < 'h30 && (a % 16) < NB) begin
            for (int j = 0; j < 8; j++) if ((a % 16) * 8 + j < NUM_CH) m[j] = 1'b1;
        end else if (a == 'h30) begin
            for (int j = 0; j < 8; j++) if (j < PRESC_W) m[j] = 1'b1;
        end else if (a == 'h31) begin
            for (int j = 0; j < 8; j++) if (j + 8 < PRESC_W) m[j] = 1'b1;
        end else if (a == 'h32 || (a >= 'h40 && a < 'h40 + NUM_CH)) begin
            m = 8'hFF;
        end
        return m;
    endfunction

    function automatic logic chan_bit(input int base, input int c);
        logic [7:0] b;
        b = m_mem[base + c / 8];
        return b[c % 8];
    endfunction

    task automatic model_step(input logic r, input logic wv, input logic [6:0] wa,
                              input logic [7:0] wd, input logic [6:0] ra);
        int presc, duty;
        logic tick, wrap, raw;
        logic [NUM_CH-1:0] o;
        if (r) begin
            for (int i = 0; i < 128; i++) m_mem[i] = '0;
            for (int c = 0; c < NUM_CH; c++) m_duty_a[c] = 0;
            m_pcnt = 0; m_cnt = 0; m_top_a = 0;
            m_out = '0; m_ps = 1'b0; m_rd = '0;
            return;
        end
        presc = int'(m_mem['h31]) * 256 + int'(m_mem['h30]);
        tick  = (m_pcnt == presc);
        wrap  = tick && (m_cnt == m_top_a);
        for (int c = 0; c < NUM_CH; c++) begin
            duty = m_duty_a[c];
            raw  = (duty == 255 || duty > m_top_a) ? 1'b1 : (m_cnt < duty);
            if (!chan_bit('h00, c))      o[c] = 1'b0;
            else if (!chan_bit('h10, c)) o[c] = ~chan_bit('h20, c);
            else                         o[c] = raw ^ chan_bit('h20, c);
        end
        m_rd = m_mem[ra];
        if (wv && (wa == 7'h30 || wa == 7'h31)) m_pcnt = 0;
        else if (tick)                         m_pcnt = 0;
        else                                   m_pcnt++;
        if (wrap) begin
            m_cnt   = 0;
            m_top_a = m_mem['h32];
            for (int c = 0; c < NUM_CH; c++) m_duty_a[c] = m_mem['h40 + c];
        end else if (tick) begin
            m_cnt++;
        end
        if (wv) m_mem[wa] = wd & store_mask(int'(wa));
        m_out = o;
        m_ps  = wrap;
    endtask

    task automatic cycle(input logic r, input logic wv, input logic [6:0] wa,
                         input logic [7:0] wd, input logic [6:0] ra);
        rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd; rd_addr = ra;
        @(posedge clk);
        model_step(r, wv, wa, wd, ra);
        #1;
        cyc++;
        check("out", 32'(dut_out), 32'(m_out));
        check("period_start", 32'(period_start), 32'(m_ps));
        check("rd_data", 32'(rd_data), 32'(m_rd));
    endtask

    task automatic step();
        cycle(1'b0, 1'b0, 7'h00, 8'h00, 7'($urandom_range(0, 127)));
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        cycle(1'b0, 1'b1, a, d, 7'($urandom_range(0, 127)));
    endtask

    task automatic wait_ps(input string tag, input int budget);
        logic found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            found = period_start;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    // Starting on a period_start cycle, count out[3] over the next period of 10 cycles.
    task automatic count_hi(input string tag, input int exp);
        int hi = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            hi += int'(dut_out[3]);
        end
        check(tag, 32'(hi), 32'(exp));
        check({tag, "_ps"}, 32'(period_start), 32'd1);
    endtask

    task automatic readback(input logic [6:0] a, input logic [7:0] exp);
        cycle(1'b0, 1'b0, 7'h00, 8'h00, a);
        check("readback", 32'(rd_data), 32'(exp));
    endtask

    initial begin
        logic [6:0] pool [16] = '{7'h00, 7'h01, 7'h02, 7'h10, 7'h11, 7'h20, 7'h21, 7'h30,
                                  7'h31, 7'h32, 7'h40, 7'h43, 7'h49, 7'h4A, 7'h7F, 7'h45};
        logic [6:0] a;
        logic [7:0] d;
        int gap;

        repeat (3) cycle(1'b1, 1'b0, 7'h00, 8'h00, 7'h00);
        check("rst_out", 32'(dut_out), 32'd0);
        check("rst_ps", 32'(period_start), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        step();
        check("ps_every_cycle", 32'(period_start), 32'd1);

        // Basic PWM: TOP=9, DUTY[3]=3 on channel 3 only.
        wr(7'h32, 8'd9);
        wr(7'h43, 8'd3);
        wr(7'h00, 8'h08);
        wr(7'h10, 8'h08);
        repeat (3) step();
        wait_ps("basic_wait", 40);
        count_hi("basic_duty3", 3);
        check("others_low", 32'(dut_out & ~10'h008), 32'd0);

        // Double buffering: mid-period write shows up next period.
        repeat (3) step();
        wr(7'h43, 8'd7);
        wait_ps("dbuf_wait", 40);
        count_hi("dbuf_duty7", 7);
        // Write landing exactly on the wrap edge is deferred by one period.
        repeat (9) step();
        wr(7'h43, 8'd2);
        check("wrap_write_ps", 32'(period_start), 32'd1);
        count_hi("wrap_old", 7);
        count_hi("wrap_new", 2);

        // Modes and polarity.
        wr(7'h10, 8'h00);
        repeat (2) step();
        check("static_pol0", 32'(dut_out[3]), 32'd1);
        wr(7'h20, 8'h08);
        repeat (2) step();
        check("static_pol1", 32'(dut_out[3]), 32'd0);
        wr(7'h10, 8'h08);
        wr(7'h43, 8'd3);
        wait_ps("pol_wait", 40);
        count_hi("pol_inverted", 7);
        wr(7'h43, 8'hFF);
        wr(7'h20, 8'h00);
        wait_ps("ff_wait", 40);
        count_hi("duty_ff", 10);
        wr(7'h00, 8'h00);
        wr(7'h20, 8'hFF);
        repeat (2) step();
        check("oen_off", 32'(dut_out), 32'd0);

        // Prescaler: PRESC=4, TOP=1 -> 10-cycle period.
        wr(7'h30, 8'd4);
        wr(7'h32, 8'd1);
        wait_ps("presc_wait1", 200);
        wait_ps("presc_wait2", 200);
        gap = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            gap++;
            if (period_start) break;
        end
        check("presc_period", 32'(gap), 32'd10);
        repeat (2) step();
        wr(7'h30, 8'd4);
        repeat (3) step();

        // Channel-count boundary.
        wr(7'h01, 8'hFF);
        readback(7'h01, 8'h03);
        wr(7'h11, 8'hFF);
        readback(7'h11, 8'h03);
        wr(7'h4A, 8'h55);
        readback(7'h4A, 8'h00);
        wr(7'h7F, 8'h12);
        readback(7'h7F, 8'h00);
        wr(7'h31, 8'hFF);
        readback(7'h31, 8'h0F);
        wr(7'h31, 8'h00);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                cycle(1'b1, 1'b0, 7'h00, 8'h00, 7'($urandom_range(0, 127)));
            end else if ($urandom_range(0, 3) == 0) begin
                a = ($urandom_range(0, 2) == 0) ? 7'(64 + $urandom_range(0, 11))
                                                : pool[$urandom_range(0, 15)];
                if (a == 7'h30)      d = 8'($urandom_range(0, 3));
                else if (a == 7'h31) d = 8'h00;
                else if (a == 7'h32) d = ($urandom_range(0, 15) == 0) ? 8'hFF
                                                                      : 8'($urandom_range(0, 15));
                else if (a >= 7'h40) d = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                                     : 8'($urandom_range(0, 16));
                else                 d = 8'($urandom);
                cycle(1'b0, 1'b1, a, d, 7'($urandom_range(0, 127)));
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
